// File: rtl/alu_wide_sequencer.sv
// Valid/ready sequencer driving an external ALU: single 32-bit ops or chained ADD+ADC 64-bit adds.
// Wide mode (EXEC_HI pass and 64-bit Z correction) is compiled in when ALU_SEQ_WIDE_EN is defined.
module alu_wide_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [4:0]  ReqFunSel,
    input  logic        ReqWide,
    input  logic [63:0] ReqA,
    input  logic [63:0] ReqB,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [63:0] RspResult,
    output logic [3:0]  RspFlags,
    output logic        RspError
);

`ifdef ALU_SEQ_WIDE_EN
    localparam int unsigned OpW    = 64;
    localparam logic [4:0]  FunAdd = 5'b10100;
    localparam logic [4:0]  FunAdc = 5'b10101;
`else
    localparam int unsigned OpW    = 32;
`endif

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StExecLo = 3'd1,
`ifdef ALU_SEQ_WIDE_EN
        StExecHi = 3'd2,
`endif
        StCapt   = 3'd3,
        StResp   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [OpW-1:0]   a_q, a_d;
    logic [OpW-1:0]   b_q, b_d;
    logic [4:0]       fun_sel_q, fun_sel_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_error_q, rsp_error_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [4:0]       alu_fun_sel_q, alu_fun_sel_d;
    logic             alu_wf_q, alu_wf_d;
    logic             req_illegal;

`ifdef ALU_SEQ_WIDE_EN
    logic             wide_q, wide_d;

    assign req_illegal = ReqWide && (ReqFunSel != FunAdd) && (ReqFunSel != FunAdc);
`else
    logic             unused_hi;

    assign req_illegal = ReqWide;
    assign unused_hi   = ^{ReqA[63:32], ReqB[63:32]};
`endif

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        fun_sel_d     = fun_sel_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_error_d   = rsp_error_q;
`ifdef ALU_SEQ_WIDE_EN
        wide_d        = wide_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (ReqValid) begin
                    a_d          = ReqA[OpW-1:0];
                    b_d          = ReqB[OpW-1:0];
                    fun_sel_d    = ReqFunSel;
`ifdef ALU_SEQ_WIDE_EN
                    wide_d       = ReqWide;
`endif
                    // Error responses report the flags as they stood when the request arrived.
                    rsp_result_d = '0;
                    rsp_flags_d  = AluFlags;
                    rsp_error_d  = req_illegal;
                    state_d      = req_illegal ? StResp : StExecLo;
                end
            end
            StExecLo: begin
                rsp_result_d[31:0] = AluOut;
`ifdef ALU_SEQ_WIDE_EN
                state_d = wide_q ? StExecHi : StCapt;
`else
                state_d = StCapt;
`endif
            end
`ifdef ALU_SEQ_WIDE_EN
            StExecHi: begin
                rsp_result_d[63:32] = AluOut;
                state_d             = StCapt;
            end
`endif
            StCapt: begin
                rsp_flags_d = AluFlags;
`ifdef ALU_SEQ_WIDE_EN
                // ALU Z only reflects the high word; a 64-bit zero also needs a zero low word.
                if (wide_q) begin
                    rsp_flags_d[3] = AluFlags[3] & (rsp_result_q[31:0] == 32'd0);
                end else begin
                    rsp_result_d[63:32] = '0;
                end
`else
                rsp_result_d[63:32] = '0;
`endif
                state_d = StResp;
            end
            StResp: begin
                if (RspReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        req_ready_d   = (state_d == StIdle);
        rsp_valid_d   = (state_d == StResp);
        alu_a_d       = '0;
        alu_b_d       = '0;
        alu_fun_sel_d = '0;
        alu_wf_d      = 1'b0;
        case (state_d)
            StExecLo: begin
                alu_a_d       = a_d[31:0];
                alu_b_d       = b_d[31:0];
                alu_fun_sel_d = fun_sel_d;
                alu_wf_d      = 1'b1;
            end
`ifdef ALU_SEQ_WIDE_EN
            StExecHi: begin
                alu_a_d       = a_d[63:32];
                alu_b_d       = b_d[63:32];
                alu_fun_sel_d = FunAdc;
                alu_wf_d      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= StIdle;
            a_q           <= '0;
            b_q           <= '0;
            fun_sel_q     <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_error_q   <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_fun_sel_q <= '0;
            alu_wf_q      <= 1'b0;
`ifdef ALU_SEQ_WIDE_EN
            wide_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            fun_sel_q     <= fun_sel_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_error_q   <= rsp_error_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_fun_sel_q <= alu_fun_sel_d;
            alu_wf_q      <= alu_wf_d;
`ifdef ALU_SEQ_WIDE_EN
            wide_q        <= wide_d;
`endif
        end
    end

    assign ReqReady  = req_ready_q;
    assign RspValid  = rsp_valid_q;
    assign RspResult = rsp_result_q;
    assign RspFlags  = rsp_flags_q;
    assign RspError  = rsp_error_q;
    assign AluA      = alu_a_q;
    assign AluB      = alu_b_q;
    assign AluFunSel = alu_fun_sel_q;
    assign AluWF     = alu_wf_q;

endmodule
